multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control FSM for the RV32I core. Sequences the shared datapath (PC, IR, register file, ALU, immediate extender, memory port) through fetch/decode/execute/memory/writeback. Drives the extender's 2-bit immediate select and every datapath enable. Talks to the unified memory port with a req/ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]; decode only, for illegal-encoding check
- br_cond  in  1  branch comparator result for current funct3
- mem_ready  in  1  memory completes the pending access this cycle
- pc_write  out  1  load PC from ALU result
- ir_write  out  1  load IR and OldPC from memory data/PC
- reg_write  out  1  register file write enable
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store, 0 = read
- alu_src_a  out  2  00 PC, 01 rs1, 10 OldPC
- alu_src_b  out  2  00 rs2, 01 ImmOut, 10 const 4, 11 Imm_U
- alu_op  out  2  00 add, 01 compare, 10 funct-decoded
- result_sel  out  2  00 ALU register, 01 memory data, 10 PC
- imm_sel  out  2  extender select: 00 I, 01 S, 10 B, 11 J
- illegal  out  1  sticky illegal-instruction flag
- instret  out  32  retired count; present only with CTRL_INSTRET_EN

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore-decoded from the state and the latched opcode class.
- RESET: all outputs 0. Unconditionally moves to FETCH on the first edge after rst_n is high.
- FETCH:
  - mem_req=1, mem_we=0, alu_src_a=00, alu_src_b=10, alu_op=00.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1 and pc_write=1 in the same cycle (PC←PC+4), then DECODE.
- DECODE:
  - Classifies opcode as R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Latches the class. Drives imm_sel: I for OP-IMM/LOAD/JALR, S for STORE, B for BRANCH, J for JAL. LUI/AUIPC use 00 and read Imm_U.
  - Any other opcode, or JALR with funct3≠000: TRAP. Otherwise EXEC.
- EXEC by class:
  - R: src 01/00, op 10.
  - OP-IMM: 01/01, op 10.
  - LOAD/STORE: 01/01, op 00.
  - BRANCH: src_a 10, src_b 01, pc_write=br_cond. Then FETCH.
  - JAL: 10/01, pc_write=1, op 00.
  - JALR: 01/01, pc_write=1.
  - LUI: src_b 11, op 00; datapath zeroes src_a for LUI class.
  - AUIPC: 10/11.
  - Next state: LOAD/STORE→MEM, BRANCH→FETCH, all others→WB.
- MEM:
  - mem_req=1, mem_we=1 for STORE.
  - Held until mem_ready. STORE then goes to FETCH, LOAD to WB.
- WB:
  - reg_write=1 for one cycle, then FETCH.
  - result_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- TRAP: illegal=1, all enables 0, stays until reset.

## Timing
- Latencies assume mem_ready=1 in its first request cycle; each wait cycle adds one:
  - BRANCH: 3 cycles
  - R, OP-IMM, JAL, JALR, LUI, AUIPC, STORE: 4 cycles
  - LOAD: 5 cycles
- mem_req and mem_we stay stable from assertion until the mem_ready cycle inclusive. mem_req is never dropped before mem_ready.
- mem_ready while mem_req=0 is ignored.
- Async reset mid-access aborts the access: mem_req drops immediately, state becomes RESET, illegal clears.
- pc_write and ir_write are single-cycle pulses. reg_write is never asserted outside WB.

## Configuration
- CTRL_INSTRET_EN defined:
  - 32-bit instret counter, 0 at reset.
  - Increments on the cycle an instruction leaves its last state: BRANCH EXEC, STORE MEM, or WB.
  - Wraps 0xFFFFFFFF→0. Never increments in TRAP.
- Undefined: no counter and no instret port.

## Structure
- Shared package rv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - imm_sel, alu_src, alu_op, result_sel encodings (reused by datapath and extender)
- One sub-module, ctrl_opdecode: combinational opcode/funct3 to class plus legal flag. FSM and output decode stay in multicycle_ctrl.

## Test plan
- Reset mid-FETCH with mem_req=1: rst_n low → mem_req=0, all outputs 0 at once. Release → FETCH after one cycle in RESET.
- ADD 0x002081B3, mem_ready always 1 → states FETCH, DECODE, EXEC, WB. reg_write high only in cycle 4, result_sel=00.
- LW 0x0040A183 with mem_ready low for 2 cycles in MEM:
  - mem_req held 3 cycles, mem_we=0, imm_sel=00.
  - WB result_sel=01; total 7 cycles.
- BEQ, opcode 1100011:
  - br_cond=1 → pc_write pulse in EXEC, imm_sel=10; br_cond=0 → no pulse.
  - Both return to FETCH after 3 cycles.
- Opcode 1111111 → TRAP after DECODE. illegal=1 persists 20 cycles, no enables asserted.
- With CTRL_INSTRET_EN: 3 ADDs then 1 BEQ → instret=4. Forcing the counter to 0xFFFFFFFF and retiring one → 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// rv_ctrl_pkg
// Shared encodings for the RV32I multicycle controller, datapath and extender.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_OPIMM  = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_BRANCH = 4'd4,
        CL_JAL    = 4'd5,
        CL_JALR   = 4'd6,
        CL_LUI    = 4'd7,
        CL_AUIPC  = 4'd8
    } iclass_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_IMMU = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC  = 2'b10;

    // U-type classes read Imm_U directly, so the extender select stays at 00.
    function automatic logic [1:0] imm_sel_for(input iclass_t cls);
        case (cls)
            CL_STORE:  imm_sel_for = IMM_S;
            CL_BRANCH: imm_sel_for = IMM_B;
            CL_JAL:    imm_sel_for = IMM_J;
            default:   imm_sel_for = IMM_I;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_opdecode.sv
// ============================================================================
// ctrl_opdecode
// Combinational opcode/funct3 classifier with legal-encoding flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_opdecode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output iclass_t    o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = CL_R;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_R:      o_class = CL_R;
            OPC_OPIMM:  o_class = CL_OPIMM;
            OPC_LOAD:   o_class = CL_LOAD;
            OPC_STORE:  o_class = CL_STORE;
            OPC_BRANCH: o_class = CL_BRANCH;
            OPC_JAL:    o_class = CL_JAL;
            OPC_JALR: begin
                o_class = CL_JALR;
                o_legal = (i_funct3 == 3'b000);
            end
            OPC_LUI:    o_class = CL_LUI;
            OPC_AUIPC:  o_class = CL_AUIPC;
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// RV32I multicycle control FSM; optional retired-instruction counter is
// enabled by defining CTRL_INSTRET_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        br_cond,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_sel,
    output logic [1:0]  imm_sel,
    output logic        illegal
`ifdef CTRL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    state_t  r_state;
    state_t  w_next;
    iclass_t r_class;
    iclass_t w_class;
    logic    w_legal;

    ctrl_opdecode u_opdecode (
        .i_opcode (opcode),
        .i_funct3 (funct3),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET;
            r_class <= CL_R;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_class <= w_class;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET:  w_next = ST_FETCH;
            ST_FETCH:  if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: w_next = w_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (r_class)
                    CL_LOAD, CL_STORE: w_next = ST_MEM;
                    CL_BRANCH:         w_next = ST_FETCH;
                    default:           w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) w_next = (r_class == CL_STORE) ? ST_FETCH : ST_WB;
            end
            ST_WB:     w_next = ST_FETCH;
            ST_TRAP:   w_next = ST_TRAP;
            default:   w_next = ST_RESET;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_sel = RES_ALU;
        imm_sel    = IMM_I;
        illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                imm_sel = w_legal ? imm_sel_for(w_class) : IMM_I;
            end
            ST_EXEC: begin
                imm_sel = imm_sel_for(r_class);
                case (r_class)
                    CL_R: begin
                        alu_src_a = SRCA_RS1;
                        alu_op    = ALUOP_FUNCT;
                    end
                    CL_OPIMM: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALUOP_FUNCT;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                    end
                    CL_BRANCH: begin
                        alu_src_a = SRCA_OLDPC;
                        alu_src_b = SRCB_IMM;
                        pc_write  = br_cond;
                    end
                    CL_JAL: begin
                        alu_src_a = SRCA_OLDPC;
                        alu_src_b = SRCB_IMM;
                        pc_write  = 1'b1;
                    end
                    CL_JALR: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        pc_write  = 1'b1;
                    end
                    CL_LUI:   alu_src_b = SRCB_IMMU;
                    CL_AUIPC: begin
                        alu_src_a = SRCA_OLDPC;
                        alu_src_b = SRCB_IMMU;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                imm_sel = imm_sel_for(r_class);
                mem_req = 1'b1;
                mem_we  = (r_class == CL_STORE);
            end
            ST_WB: begin
                imm_sel   = imm_sel_for(r_class);
                reg_write = 1'b1;
                case (r_class)
                    CL_LOAD:         result_sel = RES_MEM;
                    CL_JAL, CL_JALR: result_sel = RES_PC;
                    default:         result_sel = RES_ALU;
                endcase
            end
            ST_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_INSTRET_EN
    logic        w_retire;
    logic [31:0] r_instret;

    // Counts on the final cycle of each instruction; TRAP never reaches these states.
    assign w_retire = ((r_state == ST_EXEC) && (r_class == CL_BRANCH))
                   || ((r_state == ST_MEM) && (r_class == CL_STORE) && mem_ready)
                   || (r_state == ST_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// Table-driven checks of per-instruction sequencing plus reset/trap/wait cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        br_cond = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, reg_write, mem_req, mem_we, illegal;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_sel, imm_sel;
`ifdef CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .br_cond    (br_cond),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_sel (result_sel),
        .imm_sel    (imm_sel),
        .illegal    (illegal)
`ifdef CTRL_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      nm;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       br;
        int         lat;
        logic [1:0] srca;
        logic       chk_a;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       chk_op;
        int         pcw;
        int         regw;
        logic [1:0] rsel;
        logic [1:0] imm;
        logic       chk_imm;
        int         mreq;
        int         mwe;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {pc_write, ir_write, reg_write, mem_req, mem_we, alu_src_a, alu_src_b,
                alu_op, result_sel, imm_sel, illegal};
    endfunction

    // Leaves the DUT in FETCH, just after a rising edge, with mem_ready low.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; mem_wait stalls the MEM state.
    task automatic run_instr(input vec_t v, input int mem_wait);
        int L;
        int pcw, irw, regw, regw_cyc, mreq, mwe;
        logic [1:0] a3, b3, op3, imm2, imm3, rsel;
        logic fetch_ok;
        L = v.lat + mem_wait;
        pcw = 0; irw = 0; regw = 0; regw_cyc = 0; mreq = 0; mwe = 0;
        a3 = '0; b3 = '0; op3 = '0; imm2 = '0; imm3 = '0; rsel = '0; fetch_ok = 1'b0;
        opcode = v.opc;
        funct3 = v.f3;
        br_cond = v.br;
        for (int c = 1; c <= L + 1; c++) begin
            if (c == L + 1)
                mem_ready = 1'b0;
            else
                mem_ready = (c >= 4 && c < 4 + mem_wait) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c <= L) begin
                pcw  += int'(pc_write);
                irw  += int'(ir_write);
                mreq += int'(mem_req);
                mwe  += int'(mem_we);
                if (reg_write) begin
                    regw++;
                    regw_cyc = c;
                    rsel = result_sel;
                end
                if (c == 2) imm2 = imm_sel;
                if (c == 3) begin
                    a3 = alu_src_a; b3 = alu_src_b; op3 = alu_op; imm3 = imm_sel;
                end
            end else begin
                fetch_ok = mem_req && !mem_we && !ir_write && (alu_src_b == 2'b10);
            end
            @(posedge clk);
            #1;
        end
        chk({v.nm, "/back_to_fetch"}, {31'd0, fetch_ok}, 32'd1);
        if (v.chk_a) chk({v.nm, "/exec_src_a"}, {30'd0, a3}, {30'd0, v.srca});
        chk({v.nm, "/exec_src_b"}, {30'd0, b3}, {30'd0, v.srcb});
        if (v.chk_op) chk({v.nm, "/exec_alu_op"}, {30'd0, op3}, {30'd0, v.aluop});
        if (v.chk_imm) begin
            chk({v.nm, "/decode_imm_sel"}, {30'd0, imm2}, {30'd0, v.imm});
            chk({v.nm, "/exec_imm_sel"}, {30'd0, imm3}, {30'd0, v.imm});
        end
        chk({v.nm, "/pc_write_pulses"}, pcw, v.pcw);
        chk({v.nm, "/ir_write_pulses"}, irw, 1);
        chk({v.nm, "/reg_write_cycles"}, regw, v.regw);
        if (v.regw > 0) begin
            chk({v.nm, "/reg_write_cycle_no"}, regw_cyc, L);
            chk({v.nm, "/wb_result_sel"}, {30'd0, rsel}, {30'd0, v.rsel});
        end
        chk({v.nm, "/mem_req_cycles"}, mreq, v.mreq + ((v.mreq > 1) ? mem_wait : 0));
        chk({v.nm, "/mem_we_cycles"}, mwe, v.mwe);
        chk({v.nm, "/illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    // FETCH then DECODE of an illegal encoding, then n cycles observed in TRAP.
    task automatic run_trap(input string nm, input logic [6:0] opc, input logic [2:0] f3, input int n);
        int bad_ill, bad_en;
        bad_ill = 0; bad_en = 0;
        opcode = opc;
        funct3 = f3;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk({nm, "/decode_not_illegal"}, {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            mem_ready = i[0];
            br_cond = 1'b1;
            @(negedge clk);
            if (illegal !== 1'b1) bad_ill++;
            if ({pc_write, ir_write, reg_write, mem_req, mem_we} !== 5'd0) bad_en++;
            @(posedge clk);
            #1;
        end
        br_cond = 1'b0;
        chk({nm, "/trap_illegal_bad_cycles"}, bad_ill, 0);
        chk({nm, "/trap_enable_bad_cycles"}, bad_en, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           nm       opc         f3    br   lat srca  ca srcb  op    co pcw rw rsel  imm   ci mreq mwe
        vecs[0] = '{"ADD",   7'b0110011, 3'd0, 1'b0, 4, 2'b01, 1, 2'b00, 2'b10, 1, 1, 1, 2'b00, 2'b00, 0, 1, 0};
        vecs[1] = '{"ADDI",  7'b0010011, 3'd0, 1'b0, 4, 2'b01, 1, 2'b01, 2'b10, 1, 1, 1, 2'b00, 2'b00, 1, 1, 0};
        vecs[2] = '{"SW",    7'b0100011, 3'd2, 1'b0, 4, 2'b01, 1, 2'b01, 2'b00, 1, 1, 0, 2'b00, 2'b01, 1, 2, 1};
        vecs[3] = '{"LW",    7'b0000011, 3'd2, 1'b0, 5, 2'b01, 1, 2'b01, 2'b00, 1, 1, 1, 2'b01, 2'b00, 1, 2, 0};
        vecs[4] = '{"BEQ_T", 7'b1100011, 3'd0, 1'b1, 3, 2'b10, 1, 2'b01, 2'b00, 0, 2, 0, 2'b00, 2'b10, 1, 1, 0};
        vecs[5] = '{"BNE_N", 7'b1100011, 3'd1, 1'b0, 3, 2'b10, 1, 2'b01, 2'b00, 0, 1, 0, 2'b00, 2'b10, 1, 1, 0};
        vecs[6] = '{"JAL",   7'b1101111, 3'd0, 1'b0, 4, 2'b10, 1, 2'b01, 2'b00, 1, 2, 1, 2'b10, 2'b11, 1, 1, 0};
        vecs[7] = '{"JALR",  7'b1100111, 3'd0, 1'b0, 4, 2'b01, 1, 2'b01, 2'b00, 0, 2, 1, 2'b10, 2'b00, 1, 1, 0};
        vecs[8] = '{"LUI",   7'b0110111, 3'd0, 1'b0, 4, 2'b00, 0, 2'b11, 2'b00, 1, 1, 1, 2'b00, 2'b00, 1, 1, 0};
        vecs[9] = '{"AUIPC", 7'b0010111, 3'd0, 1'b0, 4, 2'b10, 1, 2'b11, 2'b00, 0, 1, 1, 2'b00, 2'b00, 1, 1, 0};

        // Reset state and release into FETCH.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_all_outputs_zero", {14'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_still_idle", {14'd0, all_outs()}, 32'd0);
        @(posedge clk);
        #1;
        chk("release_enters_fetch_mem_req", {31'd0, mem_req}, 32'd1);

        // Asynchronous reset in the middle of a pending fetch.
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_fetch_outputs", {14'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_release_in_reset", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("after_release_fetch", {31'd0, mem_req}, 32'd1);

        for (int i = 0; i < 10; i++) run_instr(vecs[i], 0);

        // Load with two wait cycles in MEM.
        run_instr(vecs[3], 2);

        run_trap("TRAP_7F", 7'b1111111, 3'd0, 20);
        do_reset();
        chk("reset_clears_illegal", {31'd0, illegal}, 32'd0);
        run_trap("TRAP_JALR_F3", 7'b1100111, 3'd1, 4);

`ifdef CTRL_INSTRET_EN
        do_reset();
        chk("instret_reset", instret, 32'd0);
        run_instr(vecs[0], 0);
        run_instr(vecs[0], 0);
        run_instr(vecs[0], 0);
        run_instr(vecs[4], 0);
        chk("instret_after_4", instret, 32'd4);
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        run_instr(vecs[0], 0);
        chk("instret_wrap", instret, 32'd0);
        run_trap("TRAP_CNT", 7'b1111111, 3'd0, 5);
        chk("instret_no_count_in_trap", instret, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
